switch_route_compute: RTL and testbench

//  Route-computation stage between switch input buffers and VC/switch allocation.

---
 rtl/chiplet_types_pkg.sv | 15 +
 rtl/switch_pkg.sv | 29 ++
 rtl/switch_rr_arbiter.sv | 49 ++++
 rtl/switch_route_compute.sv | 153 +++++++++++++++
 tb/tb_switch_route_compute.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chiplet_types_pkg.sv
// Shared flit and node-id types for the chiplet fabric.
package chiplet_types_pkg;

    localparam int unsigned TOTAL_NODES = 4;
    localparam int unsigned NODE_W      = (TOTAL_NODES > 1) ? $clog2(TOTAL_NODES) : 1;

    typedef logic [NODE_W-1:0] node_id_t;

    // Routing-relevant header fields of a head flit.
    typedef struct packed {
        node_id_t dest;
        logic     vc;
    } flit_t;

endpackage

// File: rtl/switch_pkg.sv
// Switch-level sizing, route table entry type and route-compute state encoding.
package switch_pkg;

    import chiplet_types_pkg::*;

    localparam int unsigned NUM_BUFFERS  = 4;
    localparam int unsigned NUM_OUTPORTS = 5;
    localparam int unsigned TABLE_SIZE   = 8;
    localparam int unsigned PORT_W       = $clog2(NUM_OUTPORTS);
    localparam int unsigned BUF_W        = $clog2(NUM_BUFFERS);

    typedef logic [PORT_W-1:0] port_t;

    typedef struct packed {
        node_id_t dest;
        port_t    port;
    } route_lut_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ROUTED
    } rc_state_e;

    function automatic node_id_t get_dest(input flit_t flit);
        return flit.dest;
    endfunction

endpackage

// File: rtl/switch_rr_arbiter.sv
// Round-robin picker: lowest-index request at or after the pointer; pointer moves past each accepted grant.
module switch_rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic             gnt_valid_c,
    output logic [IDX_W-1:0] gnt_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    int unsigned      cand;

    always_comb begin
        gnt_valid_c = 1'b0;
        gnt_idx_c   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!gnt_valid_c && req[IDX_W'(cand)]) begin
                gnt_valid_c = 1'b1;
                gnt_idx_c   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_valid_c) begin
            ptr_d = (gnt_idx_c == IDX_W'(N - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/switch_route_compute.sv
// Route computation: one shared two-cycle LUT engine serves waiting head flits round-robin;
// each buffer holds its result until the packet's tail leaves.
module switch_route_compute
    import chiplet_types_pkg::*;
    import switch_pkg::*;
(
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_BUFFERS-1:0]  head_valid,
    input  flit_t                   head_flit [NUM_BUFFERS],
    input  logic [NUM_BUFFERS-1:0]  tail_sent,
    input  route_lut_entry_t        route_lut [TABLE_SIZE],
    input  logic [NUM_OUTPORTS-1:0] dateline,
    output logic [NUM_BUFFERS-1:0]  route_valid,
    output port_t                   out_port [NUM_BUFFERS],
    output logic [NUM_BUFFERS-1:0]  out_vc,
    output logic [NUM_BUFFERS-1:0]  route_miss
);

    rc_state_e              state_q [NUM_BUFFERS];
    rc_state_e              state_d [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0] route_valid_q, route_valid_d;
    logic [NUM_BUFFERS-1:0] out_vc_q, out_vc_d;
    logic [NUM_BUFFERS-1:0] route_miss_q, route_miss_d;
    port_t                  out_port_q [NUM_BUFFERS];
    port_t                  out_port_d [NUM_BUFFERS];

    logic                   busy_q, busy_d;
    logic [BUF_W-1:0]       sel_idx_q, sel_idx_d;
    flit_t                  sel_flit_q, sel_flit_d;

    logic [NUM_BUFFERS-1:0] req_c;
    logic                   gnt_valid_c;
    logic [BUF_W-1:0]       gnt_idx_c;
    logic                   hit_c;
    port_t                  hit_port_c;
    logic                   wb_vc_c;

    // A buffer already in the compare stage must not be picked a second time.
    always_comb begin
        req_c = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            req_c[i] = (state_q[i] == WAIT) && !(busy_q && (sel_idx_q == BUF_W'(i)));
        end
    end

    switch_rr_arbiter #(
        .N (NUM_BUFFERS)
    ) u_rr_arbiter (
        .clk         (clk),
        .n_rst       (n_rst),
        .req         (req_c),
        .advance     (gnt_valid_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Parallel compare, lowest matching entry wins; a miss ejects locally on VC 0.
    always_comb begin
        hit_c      = 1'b0;
        hit_port_c = '0;
        for (int t = 0; t < TABLE_SIZE; t++) begin
            if (!hit_c && (route_lut[t].dest == get_dest(sel_flit_q))) begin
                hit_c      = 1'b1;
                hit_port_c = route_lut[t].port;
            end
        end
        wb_vc_c = 1'b0;
        if (hit_c) begin
            wb_vc_c = sel_flit_q.vc;
            if (32'(hit_port_c) < NUM_OUTPORTS) begin
                wb_vc_c = dateline[hit_port_c] | sel_flit_q.vc;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        route_valid_d = route_valid_q;
        out_vc_d      = out_vc_q;
        route_miss_d  = route_miss_q;
        out_port_d    = out_port_q;
        busy_d        = gnt_valid_c;
        sel_idx_d     = sel_idx_q;
        sel_flit_d    = sel_flit_q;

        if (gnt_valid_c) begin
            sel_idx_d  = gnt_idx_c;
            sel_flit_d = head_flit[gnt_idx_c];
        end

        for (int i = 0; i < NUM_BUFFERS; i++) begin
            unique case (state_q[i])
                IDLE: begin
                    if (head_valid[i]) begin
                        state_d[i] = WAIT;
                    end
                end
                WAIT: begin
                    if (busy_q && (sel_idx_q == BUF_W'(i))) begin
                        state_d[i]       = ROUTED;
                        route_valid_d[i] = 1'b1;
                        out_port_d[i]    = hit_c ? hit_port_c : '0;
                        out_vc_d[i]      = wb_vc_c;
                        route_miss_d[i]  = !hit_c;
                    end
                end
                ROUTED: begin
                    if (tail_sent[i]) begin
                        state_d[i]       = IDLE;
                        route_valid_d[i] = 1'b0;
                        out_port_d[i]    = '0;
                        out_vc_d[i]      = 1'b0;
                        route_miss_d[i]  = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                state_q[i]    <= IDLE;
                out_port_q[i] <= '0;
            end
            route_valid_q <= '0;
            out_vc_q      <= '0;
            route_miss_q  <= '0;
            busy_q        <= 1'b0;
            sel_idx_q     <= '0;
            sel_flit_q    <= '0;
        end else begin
            state_q       <= state_d;
            out_port_q    <= out_port_d;
            route_valid_q <= route_valid_d;
            out_vc_q      <= out_vc_d;
            route_miss_q  <= route_miss_d;
            busy_q        <= busy_d;
            sel_idx_q     <= sel_idx_d;
            sel_flit_q    <= sel_flit_d;
        end
    end

    assign route_valid = route_valid_q;
    assign out_port    = out_port_q;
    assign out_vc      = out_vc_q;
    assign route_miss  = route_miss_q;

endmodule

// File: tb/tb_switch_route_compute.sv
// Scoreboard bench for switch_route_compute: directed scenarios plus randomized traffic.
module tb_switch_route_compute;

    import chiplet_types_pkg::*;
    import switch_pkg::*;

    typedef struct packed {
        port_t port;
        logic  vc;
        logic  miss;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    n_rst;
    logic [NUM_BUFFERS-1:0]  head_valid;
    flit_t                   head_flit [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0]  tail_sent;
    route_lut_entry_t        route_lut [TABLE_SIZE];
    logic [NUM_OUTPORTS-1:0] dateline;
    logic [NUM_BUFFERS-1:0]  route_valid;
    port_t                   out_port [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0]  out_vc;
    logic [NUM_BUFFERS-1:0]  route_miss;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q [NUM_BUFFERS][$];
    int   bstate [NUM_BUFFERS];
    logic keep_hv [NUM_BUFFERS];
    int   wb_log [$];
    int   wb_cyc [$];

    switch_route_compute dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .head_valid  (head_valid),
        .head_flit   (head_flit),
        .tail_sent   (tail_sent),
        .route_lut   (route_lut),
        .dateline    (dateline),
        .route_valid (route_valid),
        .out_port    (out_port),
        .out_vc      (out_vc),
        .route_miss  (route_miss)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    a_tail_routed: assert property (@(posedge clk) disable iff (!n_rst) (tail_sent & ~route_valid) == '0)
        else $error("FAIL tail_sent_unrouted tail=%b route_valid=%b", tail_sent, route_valid);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: first table entry whose dest matches; dateline on the chosen port forces VC 1.
    function automatic exp_t ref_route(input node_id_t d, input logic vc);
        exp_t e;
        e = '{port: '0, vc: 1'b0, miss: 1'b1};
        for (int t = 0; t < TABLE_SIZE; t++) begin
            if (route_lut[t].dest == d) begin
                e.port = route_lut[t].port;
                e.miss = 1'b0;
                e.vc   = vc | dateline[e.port];
                return e;
            end
        end
        return e;
    endfunction

    function automatic int pending();
        int c = 0;
        for (int i = 0; i < NUM_BUFFERS; i++) c += exp_q[i].size();
        return c;
    endfunction

    task automatic step();
        @(negedge clk);
        head_valid = '0;
        tail_sent  = '0;
    endtask

    task automatic issue(input int i, input node_id_t d, input logic vc);
        head_flit[i].dest = d;
        head_flit[i].vc   = vc;
        head_valid[i]     = 1'b1;
        exp_q[i].push_back(ref_route(d, vc));
        bstate[i] = 1;
    endtask

    task automatic wait_rv(input int i, output int n);
        n = 0;
        while (!route_valid[i] && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic tail_all();
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (bstate[i] == 2) begin
                tail_sent[i] = 1'b1;
                bstate[i]    = 0;
            end
        end
        step();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (pending() != 0 && n < 50) begin
            step();
            n++;
        end
        chk(name, pending(), 0);
    endtask

    task automatic flush_model();
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            exp_q[i].delete();
            bstate[i]  = 0;
            keep_hv[i] = 1'b0;
        end
        wb_log.delete();
        wb_cyc.delete();
    endtask

    task automatic lut_default();
        route_lut[0] = '{dest: 2'd2, port: 3'd3};
        route_lut[1] = '{dest: 2'd0, port: 3'd1};
        route_lut[2] = '{dest: 2'd1, port: 3'd2};
        for (int t = 3; t < TABLE_SIZE; t++) route_lut[t] = '{dest: 2'd0, port: 3'd4};
        dateline = '0;
    endtask

    task automatic do_reset();
        n_rst      = 1'b0;
        head_valid = '0;
        tail_sent  = '0;
        flush_model();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        step();
    endtask

    task automatic randomize_tables();
        int top = $urandom_range(2, 3);
        for (int t = 0; t < TABLE_SIZE; t++) begin
            route_lut[t].dest = node_id_t'($urandom_range(0, top));
            route_lut[t].port = port_t'($urandom_range(0, NUM_OUTPORTS - 1));
        end
        dateline = NUM_OUTPORTS'($urandom_range(0, (1 << NUM_OUTPORTS) - 1));
    endtask

    // Monitor: pops the expectation on each new route and checks that held routes do not move.
    initial begin : monitor
        logic [NUM_BUFFERS-1:0] prev;
        exp_t held [NUM_BUFFERS];
        exp_t e;
        prev = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) held[i] = '0;
        forever begin
            @(negedge clk);
            if (n_rst !== 1'b1) begin
                prev = '0;
            end else begin
                for (int i = 0; i < NUM_BUFFERS; i++) begin
                    if (route_valid[i] && !prev[i]) begin
                        wb_log.push_back(i);
                        wb_cyc.push_back(cyc);
                        chk($sformatf("route_expected_b%0d", i), exp_q[i].size(), 1);
                        if (exp_q[i].size() != 0) begin
                            e = exp_q[i].pop_front();
                            held[i]   = e;
                            bstate[i] = 2;
                            chk($sformatf("out_port_b%0d", i), 32'(out_port[i]), 32'(e.port));
                            chk($sformatf("out_vc_b%0d", i), 32'(out_vc[i]), 32'(e.vc));
                            chk($sformatf("route_miss_b%0d", i), 32'(route_miss[i]), 32'(e.miss));
                        end
                    end else if (route_valid[i] && prev[i]) begin
                        chk($sformatf("held_port_b%0d", i), 32'(out_port[i]), 32'(held[i].port));
                        chk($sformatf("held_vc_b%0d", i), 32'(out_vc[i]), 32'(held[i].vc));
                        chk($sformatf("held_miss_b%0d", i), 32'(route_miss[i]), 32'(held[i].miss));
                    end
                end
                prev = route_valid;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        head_valid = '0;
        tail_sent  = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) head_flit[i] = '0;
        lut_default();

        // Reset values
        n_rst = 1'b0;
        flush_model();
        repeat (2) @(negedge clk);
        chk("reset_route_valid", 32'(route_valid), 0);
        chk("reset_out_vc", 32'(out_vc), 0);
        chk("reset_route_miss", 32'(route_miss), 0);
        for (int i = 0; i < NUM_BUFFERS; i++) chk($sformatf("reset_out_port_b%0d", i), 32'(out_port[i]), 0);
        n_rst = 1'b1;
        step();

        // Basic hit and uncontended latency
        issue(0, 2'd2, 1'b0);
        wait_rv(0, n);
        chk("latency_b0", n, 3);
        chk("t1_out_port", 32'(out_port[0]), 3);
        chk("t1_route_miss", 32'(route_miss[0]), 0);

        // Dateline forces VC 1, otherwise the flit's VC passes through
        tail_all();
        dateline[3] = 1'b1;
        issue(0, 2'd2, 1'b0);
        wait_rv(0, n);
        chk("dateline_set_vc", 32'(out_vc[0]), 1);
        tail_all();
        dateline[3] = 1'b0;
        issue(0, 2'd2, 1'b0);
        wait_rv(0, n);
        chk("dateline_clr_vc", 32'(out_vc[0]), 0);

        // Miss ejects locally and is cleared by the tail
        tail_all();
        issue(0, 2'd3, 1'b1);
        wait_rv(0, n);
        chk("miss_port", 32'(out_port[0]), 0);
        chk("miss_flag", 32'(route_miss[0]), 1);
        tail_all();
        chk("miss_cleared_valid", 32'(route_valid[0]), 0);
        chk("miss_cleared_flag", 32'(route_miss[0]), 0);

        // Table change does not disturb a held route
        issue(0, 2'd2, 1'b0);
        wait_rv(0, n);
        route_lut[0].port = 3'd4;
        repeat (3) step();
        chk("held_after_lut_change", 32'(out_port[0]), 3);
        tail_all();
        issue(0, 2'd2, 1'b0);
        wait_rv(0, n);
        chk("new_lookup_sees_lut", 32'(out_port[0]), 4);
        tail_all();

        // Four simultaneous heads drain in order, one per cycle; then RR continues from the pointer
        lut_default();
        do_reset();
        for (int i = 0; i < NUM_BUFFERS; i++) issue(i, node_id_t'(i % 3), 1'(i));
        n = 0;
        while (wb_log.size() < 4 && n < 20) begin
            step();
            n++;
        end
        chk("batch_count", wb_log.size(), 4);
        if (wb_log.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("batch_order_%0d", k), wb_log[k], k);
                chk($sformatf("batch_spacing_%0d", k), wb_cyc[k] - wb_cyc[0], k);
            end
        end
        tail_all();
        wb_log.delete();
        wb_cyc.delete();
        issue(1, 2'd1, 1'b0);
        n = 0;
        while (wb_log.size() < 1 && n < 20) begin
            step();
            n++;
        end
        issue(0, 2'd0, 1'b0);
        issue(3, 2'd2, 1'b0);
        n = 0;
        while (wb_log.size() < 3 && n < 20) begin
            step();
            n++;
        end
        chk("rr_count", wb_log.size(), 3);
        if (wb_log.size() >= 3) begin
            chk("rr_first_after_ptr", wb_log[1], 3);
            chk("rr_wrap", wb_log[2], 0);
        end
        tail_all();

        // Reset during the compare stage discards the lookup
        do_reset();
        issue(1, 2'd0, 1'b0);
        wait_rv(1, n);
        issue(0, 2'd2, 1'b0);
        step();
        step();
        n_rst = 1'b0;
        #1;
        chk("reset_mid_c1_valid", 32'(route_valid), 0);
        flush_model();
        step();
        n_rst = 1'b1;
        repeat (4) step();
        chk("post_reset_no_stale_route", 32'(route_valid), 0);
        issue(0, 2'd2, 1'b0);
        issue(1, 2'd0, 1'b1);
        drain("post_reset_drain");
        tail_all();

        // Randomized traffic, including tail and new head in the same cycle
        for (int c = 0; c < 400; c++) begin
            bit any_wait = 1'b0;
            step();
            for (int i = 0; i < NUM_BUFFERS; i++) if (bstate[i] == 1) any_wait = 1'b1;
            if (!any_wait && $urandom_range(0, 9) == 0) randomize_tables();
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                if (keep_hv[i]) begin
                    keep_hv[i] = 1'b0;
                    issue(i, head_flit[i].dest, head_flit[i].vc);
                end else if (bstate[i] == 0 && $urandom_range(0, 2) == 0) begin
                    issue(i, node_id_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                end else if (bstate[i] == 2 && $urandom_range(0, 3) == 0) begin
                    tail_sent[i] = 1'b1;
                    bstate[i]    = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        head_flit[i].dest = node_id_t'($urandom_range(0, 3));
                        head_flit[i].vc   = 1'($urandom_range(0, 1));
                        head_valid[i]     = 1'b1;
                        keep_hv[i]        = 1'b1;
                    end
                end
            end
        end
        step();
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            if (keep_hv[i]) begin
                keep_hv[i] = 1'b0;
                issue(i, head_flit[i].dest, head_flit[i].vc);
            end
        end
        drain("random_drain");
        tail_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
